// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown timer: FSM state encoding and default widths.
package countdown_pkg;

    localparam int unsigned DefWidth = 8;
    localparam int unsigned DefPreW  = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: emits one tick every presc+1 enabled cycles; clr restarts the count at zero.
module tick_gen #(
    parameter int unsigned PRE_W = countdown_pkg::DefPreW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [PRE_W-1:0] presc,
    output logic             tick
);

    logic [PRE_W-1:0] cnt_q, cnt_d;

    // Compared live against presc so a mid-run change applies at the next comparison.
    assign tick = en && !clr && (cnt_q == presc);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Prescaled countdown timer with load/start/abort commands, optional auto-reload and
// registered val/busy/expired/done outputs.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned PRE_W = DefPreW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             en,
    input  logic             abort,
    input  logic             auto_reload,
    input  logic [PRE_W-1:0] presc,
    output logic [WIDTH-1:0] val,
    output logic             busy,
    output logic             expired,
    output logic             done
);

    state_e           state_q;
    logic [WIDTH-1:0] val_q, reload_q;
    logic             busy_q, expired_q, done_q;
    logic             tick;
    logic             presc_clr;
    logic [WIDTH-1:0] start_val;

    // Prescaler held at zero outside RUN so every RUN entry starts a fresh period.
    assign presc_clr = (state_q != StRun) || abort;
    assign start_val = (state_q == StDone) ? reload_q : val_q;

    tick_gen #(
        .PRE_W (PRE_W)
    ) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .clr   (presc_clr),
        .en    (en),
        .presc (presc),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            val_q     <= '0;
            reload_q  <= '0;
            busy_q    <= 1'b0;
            expired_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            expired_q <= 1'b0;
            if (abort) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    StRun: begin
                        if (tick) begin
                            if (val_q > WIDTH'(1)) begin
                                val_q <= val_q - 1'b1;
                            end else begin
                                expired_q <= 1'b1;
                                if (auto_reload) begin
                                    val_q <= reload_q;
                                end else begin
                                    val_q   <= '0;
                                    state_q <= StDone;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                end
                            end
                        end
                    end
                    StIdle, StDone: begin
                        if (load) begin
                            val_q    <= load_val;
                            reload_q <= load_val;
                            state_q  <= StIdle;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b0;
                        end else if (start) begin
                            val_q <= start_val;
                            if (start_val == '0) begin
                                // Zero start value expires at once, skipping RUN.
                                expired_q <= 1'b1;
                                state_q   <= StDone;
                                busy_q    <= 1'b0;
                                done_q    <= 1'b1;
                            end else begin
                                state_q <= StRun;
                                busy_q  <= 1'b1;
                                done_q  <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign val     = val_q;
    assign busy    = busy_q;
    assign expired = expired_q;
    assign done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench: directed literal scenarios plus randomized traffic compared
// every cycle against a behavioural model of the timer rules.
module tb_countdown_timer;

    localparam int unsigned W    = 8;
    localparam int unsigned PW   = 4;
    localparam int unsigned VMOD = 256;
    localparam int unsigned PMOD = 16;

    logic          clk, rst;
    logic          load, start, en, abort, auto_reload;
    logic [W-1:0]  load_val;
    logic [PW-1:0] presc;
    logic [W-1:0]  val;
    logic          busy, expired, done;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 0;

    countdown_timer #(
        .WIDTH (W),
        .PRE_W (PW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .load_val    (load_val),
        .start       (start),
        .en          (en),
        .abort       (abort),
        .auto_reload (auto_reload),
        .presc       (presc),
        .val         (val),
        .busy        (busy),
        .expired     (expired),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0=idle 1=run 2=done, plain integer arithmetic.
    int          m_mode = 0;
    int unsigned m_val = 0, m_reload = 0, m_cnt = 0;
    bit          m_exp = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode = 0; m_val = 0; m_reload = 0; m_cnt = 0; m_exp = 0;
        end else begin : step
            int unsigned sv;
            m_exp = 0;
            if (abort) begin
                m_mode = 0;
                m_cnt  = 0;
            end else if (m_mode == 1) begin
                if (en) begin
                    if (m_cnt == presc) begin
                        m_cnt = 0;
                        if (m_val >= 2) begin
                            m_val = (m_val + VMOD - 1) % VMOD;
                        end else begin
                            m_exp = 1;
                            if (auto_reload) m_val = m_reload;
                            else begin
                                m_val  = 0;
                                m_mode = 2;
                            end
                        end
                    end else begin
                        m_cnt = (m_cnt + 1) % PMOD;
                    end
                end
            end else if (load) begin
                m_val    = load_val;
                m_reload = load_val;
                m_mode   = 0;
            end else if (start) begin
                sv    = (m_mode == 2) ? m_reload : m_val;
                m_val = sv;
                m_cnt = 0;
                if (sv == 0) begin
                    m_exp  = 1;
                    m_mode = 2;
                end else begin
                    m_mode = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_val", val, m_val);
            chk("model_busy", busy, (m_mode == 1) ? 1 : 0);
            chk("model_done", done, (m_mode == 2) ? 1 : 0);
            chk("model_expired", expired, m_exp);
        end
    end

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic clr_cmd();
        load = 0; start = 0; abort = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 0; load = 0; start = 0; en = 1; abort = 0; auto_reload = 0;
        load_val = '0; presc = '0;
        #3;
        chk("reset_val", val, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_expired", expired, 0);
        nxt(); nxt();
        rst = 1;
        cmp_en = 1;

        // load 3, presc 0: 3,2,1,0 then DONE
        load = 1; load_val = 8'd3; nxt(); clr_cmd();
        chk("a_load", val, 3);
        chk("a_idle", busy, 0);
        start = 1; nxt(); start = 0;
        chk("a_entry_val", val, 3);
        chk("a_entry_busy", busy, 1);
        nxt(); chk("a_val2", val, 2);
        nxt(); chk("a_val1", val, 1); chk("a_noexp", expired, 0);
        nxt(); chk("a_val0", val, 0); chk("a_exp", expired, 1);
        chk("a_done", done, 1); chk("a_busy0", busy, 0);
        nxt(); chk("a_exp_once", expired, 0); chk("a_done_lvl", done, 1);

        // load 2, presc 2: tick every 3 cycles, expiry at cycle 6
        load = 1; load_val = 8'd2; presc = 4'd2; nxt(); clr_cmd();
        start = 1; nxt(); start = 0;
        chk("b_entry", val, 2);
        for (int k = 1; k <= 6; k++) begin
            nxt();
            chk("b_val", val, (k < 3) ? 2 : ((k < 6) ? 1 : 0));
            chk("b_exp", expired, (k == 6) ? 1 : 0);
        end
        chk("b_done", done, 1);

        // auto-reload: 2,1,2,1,2
        load = 1; load_val = 8'd2; presc = 4'd0; auto_reload = 1; nxt(); clr_cmd();
        start = 1; nxt(); start = 0;
        chk("c_entry", val, 2);
        for (int k = 1; k <= 4; k++) begin
            nxt();
            chk("c_val", val, (k % 2 == 1) ? 1 : 2);
            chk("c_exp", expired, (k % 2 == 0) ? 1 : 0);
            chk("c_busy", busy, 1);
        end
        abort = 1; nxt(); clr_cmd(); auto_reload = 0;
        chk("c_abort_busy", busy, 0);
        chk("c_abort_val", val, 2);

        // pause: presc 1, en dropped 4 cycles mid-period
        load = 1; load_val = 8'd5; presc = 4'd1; nxt(); clr_cmd();
        start = 1; nxt(); start = 0;
        chk("d_entry", val, 5);
        nxt(); chk("d_half", val, 5);
        en = 0;
        for (int k = 0; k < 4; k++) begin
            nxt();
            chk("d_hold", val, 5);
            chk("d_hold_busy", busy, 1);
        end
        en = 1;
        nxt(); chk("d_resume", val, 4);
        nxt(); chk("d_mid", val, 4);
        nxt(); chk("d_next", val, 3);

        // load+abort in RUN, load ignored in RUN, load+start in DONE
        load = 1; load_val = 8'd9; abort = 1; nxt(); clr_cmd();
        chk("e_abort_val", val, 3);
        chk("e_abort_busy", busy, 0);
        chk("e_abort_done", done, 0);
        presc = 4'd0; start = 1; nxt(); start = 0;
        chk("e_run", busy, 1);
        load = 1; load_val = 8'd20; nxt(); load = 0;
        chk("e_load_ignored", val, 2);
        nxt(); nxt();
        chk("e_done", done, 1);
        load = 1; start = 1; load_val = 8'd7; nxt(); clr_cmd();
        chk("e_load_val", val, 7);
        chk("e_load_idle", busy, 0);
        chk("e_load_notdone", done, 0);

        // async reset mid-RUN, then zero-value start
        load = 1; load_val = 8'd6; nxt(); clr_cmd();
        start = 1; nxt(); start = 0;
        nxt(); nxt();
        chk("f_val4", val, 4);
        #2 rst = 0;
        #1;
        chk("f_rst_val", val, 0);
        chk("f_rst_busy", busy, 0);
        chk("f_rst_done", done, 0);
        chk("f_rst_exp", expired, 0);
        nxt();
        chk("f_rst_exp2", expired, 0);
        rst = 1; start = 1; nxt(); start = 0;
        chk("f_zero_exp", expired, 1);
        chk("f_zero_done", done, 1);
        chk("f_zero_busy", busy, 0);
        nxt();
        chk("f_zero_once", expired, 0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            abort = ($urandom_range(31) == 0);
            load  = ($urandom_range(7) == 0);
            start = ($urandom_range(3) == 0);
            en    = ($urandom_range(7) != 0);
            if ($urandom_range(63) == 0) auto_reload = 1'($urandom_range(1));
            if ($urandom_range(31) == 0)
                presc = ($urandom_range(7) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(3));
            load_val = ($urandom_range(3) == 0) ? 8'($urandom_range(255)) : 8'($urandom_range(6));
            rst = ($urandom_range(499) != 0);
            nxt();
        end
        rst = 1; clr_cmd();
        nxt();
        cmp_en = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
